// File: rtl/ts_udp_rx.sv
// ts_udp_rx: filters Ethernet/IPv4/UDP frames addressed to this node and
// emits the UDP payload as a 188/204-byte TS packet stream, one cycle
// behind the incoming bytes, with accepted/rejected frame counters.
module ts_udp_rx #(
  parameter int unsigned MAX_PKTS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        len_188_204n,
  input  logic [47:0] i_MacLocal,
  input  logic [31:0] i_IpLocal,
  input  logic [15:0] i_PortLocal,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic [7:0]  ts_data,
  output logic        ts_valid,
  output logic        ts_start,
  output logic        ts_end,
  output logic        ts_err,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_drop_cnt
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned K_W   = 8;

  localparam logic [LEN_W-1:0] MAX_P188 = LEN_W'(MAX_PKTS * 188);
  localparam logic [LEN_W-1:0] MAX_P204 = LEN_W'(MAX_PKTS * 204);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;
  localparam logic [2:0] S_SKIP = 3'd5;

  logic [2:0]       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             mac_loc, mac_loc_n, mac_loc_c;
  logic             mac_bc, mac_bc_n, mac_bc_c;
  logic             mac_mc, mac_mc_n, mac_mc_c;
  logic             len188, len188_n;
  logic [7:0]       len_hi, len_hi_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [K_W-1:0]   k, k_n, k_last;
  logic             part, part_n;
  logic [7:0]       mac_exp, mc_exp;
  logic [LEN_W-1:0] udp_len, pay_len, pay_max;
  logic             hdr_bad;
  logic [7:0]       ts_data_n;
  logic             ts_valid_n, ts_start_n, ts_end_n, ts_err_n;
  logic             ok_inc, drop_inc;

  assign k_last  = len188 ? K_W'(187) : K_W'(203);
  assign pay_max = len188 ? MAX_P188 : MAX_P204;

  // Header check for the byte on rx_data; idx is its frame position (0 in IDLE)
  always_comb begin
    mac_loc_c = (state == S_IDLE) ? 1'b1 : mac_loc;
    mac_bc_c  = (state == S_IDLE) ? 1'b1 : mac_bc;
    mac_mc_c  = (state == S_IDLE) ? 1'b1 : mac_mc;
    mac_exp   = 8'h00;
    mc_exp    = 8'h00;
    udp_len   = {len_hi, rx_data};
    pay_len   = udp_len - LEN_W'(8);
    hdr_bad   = 1'b0;
    case (idx)
      6'd0: begin mac_exp = i_MacLocal[47:40]; mc_exp = 8'h01; end
      6'd1: begin mac_exp = i_MacLocal[39:32]; mc_exp = 8'h00; end
      6'd2: begin mac_exp = i_MacLocal[31:24]; mc_exp = 8'h5E; end
      6'd3: mac_exp = i_MacLocal[23:16];
      6'd4: mac_exp = i_MacLocal[15:8];
      6'd5: mac_exp = i_MacLocal[7:0];
      6'd12: hdr_bad = (rx_data != 8'h08);
      6'd13: hdr_bad = (rx_data != 8'h00);
      6'd14: hdr_bad = (rx_data != 8'h45);
      6'd23: hdr_bad = (rx_data != 8'h11);
      6'd30: hdr_bad = (rx_data != i_IpLocal[31:24]);
      6'd31: hdr_bad = (rx_data != i_IpLocal[23:16]);
      6'd32: hdr_bad = (rx_data != i_IpLocal[15:8]);
      6'd33: hdr_bad = (rx_data != i_IpLocal[7:0]);
      6'd36: hdr_bad = (rx_data != i_PortLocal[15:8]);
      6'd37: hdr_bad = (rx_data != i_PortLocal[7:0]);
      6'd39: hdr_bad = (pay_len == LEN_W'(0)) || (pay_len > pay_max);
      default: ;
    endcase
    if (idx <= 6'd5) begin
      mac_loc_c = mac_loc_c & (rx_data == mac_exp);
      mac_bc_c  = mac_bc_c & (rx_data == 8'hFF);
      if (idx <= 6'd2) mac_mc_c = mac_mc_c & (rx_data == mc_exp);
      if (!(mac_loc_c || mac_bc_c || mac_mc_c)) hdr_bad = 1'b1;
    end
  end

  // Next-state, next-output and counter-event logic
  always_comb begin
    state_n    = state;
    idx_n      = '0;
    mac_loc_n  = mac_loc;
    mac_bc_n   = mac_bc;
    mac_mc_n   = mac_mc;
    len188_n   = len188;
    len_hi_n   = len_hi;
    rem_n      = rem;
    k_n        = k;
    part_n     = 1'b0;
    ts_data_n  = 8'h00;
    ts_valid_n = 1'b0;
    ts_start_n = 1'b0;
    ts_end_n   = 1'b0;
    ts_err_n   = part;
    ok_inc     = 1'b0;
    drop_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_dv) begin
          len188_n = len_188_204n;
          if (!enable || hdr_bad) begin
            state_n  = S_DROP;
            drop_inc = 1'b1;
          end else begin
            state_n   = S_HDR;
            idx_n     = 6'd1;
            mac_loc_n = mac_loc_c;
            mac_bc_n  = mac_bc_c;
            mac_mc_n  = mac_mc_c;
          end
        end
      end
      S_HDR: begin
        if (!rx_dv) begin
          state_n  = S_IDLE;
          drop_inc = 1'b1;
        end else if (hdr_bad) begin
          state_n  = S_DROP;
          drop_inc = 1'b1;
        end else begin
          idx_n     = idx + 6'd1;
          mac_loc_n = mac_loc_c;
          mac_bc_n  = mac_bc_c;
          mac_mc_n  = mac_mc_c;
          if (idx == 6'd38) len_hi_n = rx_data;
          if (idx == 6'd39) rem_n = pay_len;
          if (idx == 6'd41) begin
            state_n = S_PAY;
            k_n     = '0;
          end
        end
      end
      S_PAY: begin
        if (!rx_dv) begin
          state_n  = S_IDLE;
          drop_inc = 1'b1;
          ts_err_n = 1'b1;
        end else if (k == '0 && rx_data != 8'h47) begin
          state_n  = S_DROP;
          drop_inc = 1'b1;
          ts_err_n = 1'b1;
        end else begin
          ts_data_n  = rx_data;
          ts_valid_n = 1'b1;
          ts_start_n = (k == '0);
          ts_end_n   = (k == k_last);
          k_n        = (k == k_last) ? '0 : k + K_W'(1);
          rem_n      = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_n = S_TAIL;
            ok_inc  = 1'b1;
            part_n  = (k != k_last);
          end
        end
      end
      S_TAIL, S_DROP, S_SKIP: begin
        if (!rx_dv) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and output registers with saturating frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= rx_dv ? S_SKIP : S_IDLE;
      idx            <= '0;
      mac_loc        <= 1'b0;
      mac_bc         <= 1'b0;
      mac_mc         <= 1'b0;
      len188         <= 1'b0;
      len_hi         <= 8'h00;
      rem            <= '0;
      k              <= '0;
      part           <= 1'b0;
      ts_data        <= 8'h00;
      ts_valid       <= 1'b0;
      ts_start       <= 1'b0;
      ts_end         <= 1'b0;
      ts_err         <= 1'b0;
      frame_ok_cnt   <= 16'h0000;
      frame_drop_cnt <= 16'h0000;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      mac_loc  <= mac_loc_n;
      mac_bc   <= mac_bc_n;
      mac_mc   <= mac_mc_n;
      len188   <= len188_n;
      len_hi   <= len_hi_n;
      rem      <= rem_n;
      k        <= k_n;
      part     <= part_n;
      ts_data  <= ts_data_n;
      ts_valid <= ts_valid_n;
      ts_start <= ts_start_n;
      ts_end   <= ts_end_n;
      ts_err   <= ts_err_n;
      if (ok_inc && frame_ok_cnt != 16'hFFFF) frame_ok_cnt <= frame_ok_cnt + 16'd1;
      if (drop_inc && frame_drop_cnt != 16'hFFFF) frame_drop_cnt <= frame_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ts_udp_rx.sv
// Testbench for ts_udp_rx: directed frames, expected TS outputs queued by the
// driver with their due cycle, popped and compared by an output monitor.
module tb_ts_udp_rx;

  localparam logic [47:0] MAC_LOC = 48'h02_11_22_33_44_55;
  localparam logic [47:0] MAC_BC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_MC  = 48'h01_00_5E_7F_00_01;
  localparam logic [47:0] MAC_BAD = 48'h02_11_22_33_44_56;
  localparam logic [31:0] IP_LOC  = 32'hE0_00_00_01;
  localparam logic [15:0] PORT    = 16'h138C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        ln188 = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  ts_data;
  logic        ts_valid, ts_start, ts_end, ts_err;
  logic [15:0] frame_ok_cnt, frame_drop_cnt;

  ts_udp_rx #(.MAX_PKTS(7)) dut (
    .clk(clk), .rst(rst), .enable(enable), .len_188_204n(ln188),
    .i_MacLocal(MAC_LOC), .i_IpLocal(IP_LOC), .i_PortLocal(PORT),
    .rx_dv(rx_dv), .rx_data(rx_data),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_start(ts_start),
    .ts_end(ts_end), .ts_err(ts_err),
    .frame_ok_cnt(frame_ok_cnt), .frame_drop_cnt(frame_drop_cnt)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [31:0] stamp;
    logic [7:0]  d;
    logic        v;
    logic        s;
    logic        e;
    logic        r;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   n_valid = 0;

  logic [7:0] fr[2048];
  bit ex_out[2048], ex_st[2048], ex_en[2048], ex_ea[2048], ex_ef[2048];
  int flen = 0;
  int rst_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every cycle with TS activity must match the queue head
  always @(negedge clk) begin
    exp_t x;
    if (ts_valid) n_valid++;
    if (ts_start) n_start++;
    if (ts_valid || ts_err || ts_start || ts_end) begin
      vecs++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out cyc=%0d got v=%b d=%h s=%b e=%b r=%b, required no output",
                 cyc, ts_valid, ts_data, ts_start, ts_end, ts_err);
      end else begin
        x = sb.pop_front();
        if (x.stamp != 32'(cyc) || x.v !== ts_valid || x.s !== ts_start ||
            x.e !== ts_end || x.r !== ts_err || (x.v && x.d !== ts_data)) begin
          fails++;
          $display("FAIL ts_out got cyc=%0d v=%b d=%h s=%b e=%b r=%b required cyc=%0d v=%b d=%h s=%b e=%b r=%b",
                   cyc, ts_valid, ts_data, ts_start, ts_end, ts_err,
                   x.stamp, x.v, x.d, x.s, x.e, x.r);
        end
      end
    end
  end

  function automatic exp_t mk(input int stamp, input logic [7:0] d, input logic v,
                              input logic s, input logic e, input logic r);
    exp_t x;
    x.stamp = 32'(stamp); x.d = d; x.v = v; x.s = s; x.e = e; x.r = r;
    return x;
  endfunction

  task automatic chk(input string nm, input int got, input int req);
    vecs++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 2048; i++) begin
      ex_out[i] = 0; ex_st[i] = 0; ex_en[i] = 0; ex_ea[i] = 0; ex_ef[i] = 0;
    end
  endtask

  // Frame image with payload of npay bytes; TS sync 0x47 at each packet start
  task automatic build(input logic [47:0] dst, input logic [15:0] ulen,
                       input int npay, input bit l188);
    int pl;
    logic [15:0] tl;
    pl = l188 ? 188 : 204;
    tl = ulen + 16'd20;
    clr_exp();
    for (int i = 0; i < 2048; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) fr[i] = dst[47-8*i -: 8];
    fr[6] = 8'h02; fr[7] = 8'hAA; fr[8] = 8'hBB; fr[9] = 8'hCC; fr[10] = 8'hDD; fr[11] = 8'hEE;
    fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45;
    fr[16] = tl[15:8]; fr[17] = tl[7:0];
    fr[22] = 8'h40; fr[23] = 8'h11;
    fr[26] = 8'hC0; fr[27] = 8'hA8; fr[28] = 8'h01; fr[29] = 8'h0A;
    fr[30] = IP_LOC[31:24]; fr[31] = IP_LOC[23:16]; fr[32] = IP_LOC[15:8]; fr[33] = IP_LOC[7:0];
    fr[34] = 8'h04; fr[35] = 8'h00;
    fr[36] = PORT[15:8]; fr[37] = PORT[7:0];
    fr[38] = ulen[15:8]; fr[39] = ulen[7:0];
    for (int o = 0; o < npay; o++) begin
      fr[42+o]     = ((o % pl) == 0) ? 8'h47 : 8'(o * 3 + 1);
      ex_out[42+o] = 1;
      ex_st[42+o]  = ((o % pl) == 0);
      ex_en[42+o]  = ((o % pl) == pl - 1);
    end
    for (int j = 0; j < 4; j++) fr[42+npay+j] = 8'hC0 + 8'(j);
    flen = 42 + npay + 4;
    rst_at = -1;
  endtask

  // Drive the first n bytes, then gap cycles of rx_dv=0; queue expected outputs
  task automatic drive(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = (i == rst_at);
      rx_dv = 1'b1;
      rx_data = fr[i];
      if (rst_at < 0 || i < rst_at) begin
        if (ex_out[i]) sb.push_back(mk(cyc + 1, fr[i], 1'b1, ex_st[i], ex_en[i], 1'b0));
        if (ex_ea[i])  sb.push_back(mk(cyc + 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        if (ex_ef[i])  sb.push_back(mk(cyc + 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; rx_dv = 1'b0; rx_data = 8'h00;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rx_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic settle(input string nm, input int ok, input int drop);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_pending"}, sb.size(), 0);
    sb.delete();
    chk({nm, "_ok_cnt"}, int'(frame_ok_cnt), ok);
    chk({nm, "_drop_cnt"}, int'(frame_drop_cnt), drop);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_ts_valid", int'(ts_valid), 0);
    chk("rst_ts_err", int'(ts_err), 0);
    chk("rst_ok_cnt", int'(frame_ok_cnt), 0);
    chk("rst_drop_cnt", int'(frame_drop_cnt), 0);

    // 1: broadcast, 7 x 204-byte packets, maximum payload
    ln188 = 1'b0;
    build(MAC_BC, 16'd1436, 1428, 1'b0);
    n_start = 0; n_valid = 0;
    drive(flen, 3);
    settle("t1", 1, 0);
    chk("t1_starts", n_start, 7);
    chk("t1_valid_bytes", n_valid, 1428);

    // 2: wrong IP protocol dropped, multicast frame after 1-cycle gap accepted
    do_reset();
    build(MAC_BC, 16'd1436, 1428, 1'b0);
    fr[23] = 8'h06;
    clr_exp();
    drive(flen, 1);
    build(MAC_MC, 16'd212, 204, 1'b0);
    drive(flen, 3);
    settle("t2", 1, 1);

    // 3: 188-byte mode, second packet has bad sync
    do_reset();
    ln188 = 1'b1;
    build(MAC_LOC, 16'd384, 376, 1'b1);
    fr[42+188] = 8'h46;
    for (int i = 42 + 188; i < 2048; i++) ex_out[i] = 0;
    ex_ea[42+188] = 1;
    drive(flen, 3);
    settle("t3", 0, 1);

    // 4: rx_dv falls after 100 bytes of the third packet
    do_reset();
    build(MAC_LOC, 16'd572, 564, 1'b1);
    ex_ef[42+376+99] = 1;
    drive(42 + 376 + 100, 3);
    settle("t4", 0, 1);

    // 5: runt frame, then a good frame while disabled
    do_reset();
    build(MAC_LOC, 16'd196, 188, 1'b1);
    clr_exp();
    drive(30, 2);
    settle("t5a", 0, 1);
    enable = 1'b0;
    drive(flen, 2);
    enable = 1'b1;
    settle("t5b", 0, 2);

    // 6: reset in the middle of a frame clears counters; next frame accepted
    do_reset();
    ln188 = 1'b0;
    build(MAC_BC, 16'd212, 204, 1'b0);
    clr_exp();
    enable = 1'b0;
    drive(flen, 1);
    enable = 1'b1;
    build(MAC_BC, 16'd212, 204, 1'b0);
    drive(flen, 2);
    settle("t6a", 1, 1);
    build(MAC_BC, 16'd1436, 1428, 1'b0);
    rst_at = 500;
    drive(flen, 2);
    settle("t6b", 0, 0);
    build(MAC_BC, 16'd420, 412, 1'b0);
    ex_ef[42+411] = 1;
    drive(flen, 2);
    settle("t6c", 1, 0);

    // 7: payload ends mid-packet: accepted, ts_err after the partial packet
    do_reset();
    ln188 = 1'b1;
    build(MAC_LOC, 16'd206, 198, 1'b1);
    ex_ef[42+197] = 1;
    drive(flen, 3);
    settle("t7", 1, 0);

    // 8: port, length and MAC boundaries; single-byte payload accepted
    do_reset();
    build(MAC_LOC, 16'd196, 188, 1'b1);
    fr[37] = 8'h8D;
    clr_exp();
    drive(flen, 1);
    build(MAC_LOC, 16'd8, 0, 1'b1);
    clr_exp();
    drive(flen, 1);
    build(MAC_LOC, 16'd1325, 10, 1'b1);
    clr_exp();
    drive(flen, 1);
    build(MAC_BAD, 16'd196, 188, 1'b1);
    clr_exp();
    drive(flen, 1);
    build(MAC_LOC, 16'd9, 1, 1'b1);
    ex_ef[42] = 1;
    drive(flen, 3);
    settle("t8", 1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/ts_udp_rx.md
Name: ts_udp_rx

Overview:
Receive-side counterpart of the TS-over-IP transmit path. It takes a byte-wide Ethernet frame stream, with preamble and SFD already stripped, from the RGMII receive front end. It filters frames by MAC, IPv4, UDP and port, then extracts the UDP payload as a stream of 188- or 204-byte transport-stream packets. Its ts_data/ts_valid/ts_start/ts_end output matches the TS stream convention used by the TS packet generator, so that generator's consumers can be reused downstream.

Parameters:
MAX_PKTS, 7, maximum TS packets per UDP datagram; a larger payload drops the frame.

Ports:
clk  in  1  byte clock (the 25 MHz PHY-side clock)
rst  in  1  synchronous, active-high reset
enable  in  1  accept new frames; sampled at the first byte of each frame
len_188_204n  in  1  1 = 188-byte packets, 0 = 204-byte packets; sampled at the first byte of each frame
i_MacLocal  in  48  local MAC address
i_IpLocal  in  32  accepted IP destination address (unicast or multicast)
i_PortLocal  in  16  accepted UDP destination port
rx_dv  in  1  frame byte valid; a frame is one contiguous run of rx_dv=1
rx_data  in  8  frame byte, destination MAC first
ts_data  out  8  TS byte
ts_valid  out  1  ts_data valid
ts_start  out  1  first byte of a TS packet (0x47)
ts_end  out  1  last byte of a complete TS packet
ts_err  out  1  one-cycle pulse: the current TS packet was truncated or lost sync
frame_ok_cnt  out  16  frames accepted; saturates at 0xFFFF
frame_drop_cnt  out  16  frames rejected; saturates at 0xFFFF

Behaviour:
- Reset: all outputs 0, both counters 0, state goes to SKIP if rx_dv=1, otherwise IDLE. A reset mid-frame therefore discards the rest of that frame, and the discard is not counted.
- Byte index b counts from 0 at the first rx_dv=1 cycle after rx_dv=0. Header checks:
  - b0..5: dest MAC must be i_MacLocal, FF:FF:FF:FF:FF:FF, or have the 01:00:5E prefix.
  - b12..13 = 0x0800.
  - b14 = 0x45 (no IP options).
  - b23 = 0x11.
  - b30..33 = i_IpLocal.
  - b36..37 = i_PortLocal.
  - b38..39 = UDP length L.
  - Payload starts at b42.
- Length rule: P = L-8 (16-bit). Require 1 <= P <= MAX_PKTS*pktlen, checked at b39, otherwise reject. A P that is not a multiple of pktlen is allowed; the trailing partial packet is handled as truncation.
- IP checksum, UDP checksum and FCS are not checked. Bytes after the P payload bytes, including FCS and padding, are ignored until rx_dv falls.
- States:
  - IDLE: rx_dv=1 with enable=1 goes to HDR; rx_dv=1 with enable=0 goes to DROP.
  - HDR: any failed check goes to DROP at the failing byte. Passing b41 goes to PAY.
  - PAY: outputs P bytes, then goes to TAIL.
  - TAIL: waits for rx_dv=0, then IDLE.
  - DROP: waits for rx_dv=0, then IDLE.
  - SKIP: waits for rx_dv=0, then IDLE; no counting.
- Counters:
  - frame_drop_cnt increments once per frame on entry to DROP, including enable=0 frames.
  - A frame ending in HDR (runt) also increments frame_drop_cnt.
  - frame_ok_cnt increments once when the last payload byte is output.
- Output timing: each payload byte appears on ts_data with ts_valid=1 exactly 1 cycle after it arrives on rx_data. ts_start, ts_end and ts_err are aligned to that byte.
- Per-packet counter k runs 0..pktlen-1 and wraps at pktlen.
  - At k=0 the byte must be 0x47. If so, ts_start=1.
  - If not, ts_valid=0 for that byte, ts_err=1, the frame goes to DROP, and frame_drop_cnt increments. frame_ok_cnt does not increment for that frame. Packets already output are kept.
  - At k=pktlen-1, ts_end=1.
- Truncation:
  - If rx_dv falls in PAY, or P ends with k != 0, then ts_err pulses 1 cycle after the last valid payload byte, with ts_valid=0 on that cycle. There is no ts_end for that partial packet.
  - If rx_dv falls in PAY, frame_drop_cnt increments and frame_ok_cnt does not.
  - If P ends mid-packet, frame_ok_cnt still increments.
- rx_dv falling on the same cycle as the final payload byte is treated as a normal completion, not truncation.
- Back-to-back frames with a single rx_dv=0 cycle between them must both be processed.
- No backpressure: ts_valid follows the input rate and is never stalled.

Test Plan:
1. len_188_204n=0; frame to FF..FF / 224.0.0.1 / port 0x138C with L=8+7*204=1436 -> 7 ts_start/ts_end pairs, 1428 ts_valid bytes, each byte 1 cycle after its input, frame_ok_cnt=1.
2. Same frame with b23=0x06 -> no ts_valid, frame_drop_cnt=1; a valid frame following after a 1-cycle rx_dv gap -> accepted, frame_ok_cnt=1.
3. len_188_204n=1, L=8+2*188; second packet's sync byte = 0x46 -> first packet output complete, then ts_err pulse, frame_drop_cnt=1.
4. rx_dv falls after 100 bytes of packet 3 -> 100 bytes output without ts_end, ts_err on the next cycle, frame_drop_cnt=1.
5. Frame of 30 bytes (runt) -> frame_drop_cnt=1; enable=0 with a valid frame -> frame_drop_cnt=2, no output.
6. rst pulsed during byte 500 of a valid frame -> outputs 0 next cycle, remainder of the frame ignored, both counters 0; the next frame is accepted normally.
